// File: rtl/inst_buffer_if.sv
// Fetch/dispatch-side signal bundle for inst_buffer: the push handshake, the FWFT head and the
// occupancy flags.
interface inst_buffer_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ENTRY_W = 32
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic                push_valid;
    logic [ENTRY_W-1:0]  push_entry;
    logic                push_ready;
    logic                read_enable;
    logic                head_valid;
    logic [ENTRY_W-1:0]  head_entry;
    logic [CntW-1:0]     count;
    logic                full;
    logic                almost_full;
    logic                empty;

    // Fetch and RS side: offers entries, consumes the head.
    modport master (
        output push_valid, push_entry, read_enable,
        input  push_ready, head_valid, head_entry, count, full, almost_full, empty
    );

    // Buffer side.
    modport slave (
        input  push_valid, push_entry, read_enable,
        output push_ready, head_valid, head_entry, count, full, almost_full, empty
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular FIFO between fetch and dispatch. It presents the head entry first-word-fall-through and is
// flushed on take_branch.
module inst_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ENTRY_W  = 32,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          take_branch,
    inst_buffer_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]    head_q, head_d;
    logic [PtrW-1:0]    tail_q, tail_d;
    logic [CntW-1:0]    count_q, count_d;

    logic full, empty, push_fire, pop_fire;

    // Flags come only from the registered count, so read_enable has no path to push_ready.
    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_fire = bus.push_valid && !full;
    assign pop_fire  = bus.read_enable && !empty;

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count_q >= CntW'(AF_LEVEL));
    assign bus.count       = count_q;
    assign bus.head_valid  = !empty;
    assign bus.push_ready  = !full;
    assign bus.head_entry  = empty ? '0 : mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (take_branch) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_fire) tail_d = tail_q + PtrW'(1);
            if (pop_fire)  head_d = head_q + PtrW'(1);
            count_d = count_q + CntW'(push_fire) - CntW'(pop_fire);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; a flushed or reset push must not land in it.
    always_ff @(posedge clock) begin
        if (push_fire && !reset && !take_branch) mem_q[tail_q] <= bus.push_entry;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (count_q <= CntW'(DEPTH));
            assert ((count_q == '0) == empty);
            assert (!(push_fire && full));
        end
    end
`endif
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: reset, FWFT order, fill and full, pointer wrap, flush, and reset
// mid-stream.
module tb_inst_buffer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic take_branch = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    inst_buffer_if #(.DEPTH(8), .ENTRY_W(32)) bus ();

    inst_buffer #(.DEPTH(8), .ENTRY_W(32), .AF_LEVEL(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .take_branch (take_branch),
        .bus         (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.push_valid  = 1'b0;
        bus.push_entry  = '0;
        bus.read_enable = 1'b0;
        step();
        step();
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_empty", 32'(bus.empty), 1);
            chk("rst_count", 32'(bus.count), 0);
            chk("rst_hvalid", 32'(bus.head_valid), 0);
            chk("rst_pready", 32'(bus.push_ready), 1);
            chk("rst_head", bus.head_entry, 0);
        end

        // 2: push A,B,C then drain in order
        bus.push_valid = 1'b1;
        bus.push_entry = 32'hA0; step(); chk("p1_count", 32'(bus.count), 1);
        chk("p1_head", bus.head_entry, 32'hA0);
        bus.push_entry = 32'hB0; step(); chk("p2_count", 32'(bus.count), 2);
        chk("p2_head", bus.head_entry, 32'hA0);
        bus.push_entry = 32'hC0; step(); chk("p3_count", 32'(bus.count), 3);
        chk("p3_head", bus.head_entry, 32'hA0);
        bus.push_valid  = 1'b0;
        bus.read_enable = 1'b1;
        step(); chk("pop1_head", bus.head_entry, 32'hB0);
        step(); chk("pop2_head", bus.head_entry, 32'hC0);
        step(); chk("pop3_empty", 32'(bus.empty), 1);
        chk("pop3_count", 32'(bus.count), 0);
        bus.read_enable = 1'b0;

        // 3: fill to full, refused push with same-cycle pop
        bus.push_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.push_entry = 32'h100 + 32'(i);
            step();
            chk("fill_count", 32'(bus.count), 32'(i + 1));
            chk("fill_af", 32'(bus.almost_full), (i + 1 >= 6) ? 1 : 0);
            chk("fill_full", 32'(bus.full), (i + 1 == 8) ? 1 : 0);
        end
        chk("full_pready", 32'(bus.push_ready), 0);
        bus.push_entry  = 32'h1FF;
        bus.read_enable = 1'b1;
        step();
        chk("full_pop_count", 32'(bus.count), 7);
        chk("full_pop_full", 32'(bus.full), 0);
        bus.push_valid = 1'b0;
        for (int j = 1; j < 8; j++) begin
            chk("drain_head", bus.head_entry, 32'h100 + 32'(j));
            step();
        end
        chk("drain_empty", 32'(bus.empty), 1);
        chk("drain_head0", bus.head_entry, 0);
        bus.read_enable = 1'b0;

        // 4: streaming push/pop across pointer wrap
        bus.push_valid = 1'b1;
        bus.push_entry = 32'd0;
        step();
        chk("wrap_head0", bus.head_entry, 0);
        bus.read_enable = 1'b1;
        for (int i = 1; i < 20; i++) begin
            bus.push_entry = 32'(i);
            step();
            chk("wrap_count", 32'(bus.count), 1);
            chk("wrap_head", bus.head_entry, 32'(i));
        end
        bus.push_valid = 1'b0;
        step();
        chk("wrap_empty", 32'(bus.empty), 1);
        bus.read_enable = 1'b0;

        // 5: flush beats push and pop
        bus.push_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.push_entry = 32'h50 + 32'(i);
            step();
        end
        chk("fl_pre_count", 32'(bus.count), 5);
        take_branch     = 1'b1;
        bus.push_entry  = 32'hEE;
        bus.read_enable = 1'b1;
        step();
        chk("fl_count", 32'(bus.count), 0);
        chk("fl_empty", 32'(bus.empty), 1);
        chk("fl_head", bus.head_entry, 0);
        step();
        chk("fl_hold_count", 32'(bus.count), 0);
        take_branch     = 1'b0;
        bus.read_enable = 1'b0;
        bus.push_entry  = 32'h77;
        step();
        chk("fl_after_hvalid", 32'(bus.head_valid), 1);
        chk("fl_after_head", bus.head_entry, 32'h77);
        chk("fl_after_count", 32'(bus.count), 1);
        bus.push_valid  = 1'b0;
        bus.read_enable = 1'b1;
        step();

        // 6: pop on empty is ignored; push+pop on empty only pushes; reset mid-stream
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ie_count", 32'(bus.count), 0);
            chk("ie_empty", 32'(bus.empty), 1);
        end
        bus.push_valid = 1'b1;
        bus.push_entry = 32'h33;
        step();
        chk("pe_count", 32'(bus.count), 1);
        chk("pe_head", bus.head_entry, 32'h33);
        bus.read_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.push_entry = 32'h40 + 32'(i);
            step();
        end
        chk("mr_pre_count", 32'(bus.count), 4);
        reset = 1'b1;
        bus.read_enable = 1'b1;
        step();
        chk("mr_count", 32'(bus.count), 0);
        chk("mr_empty", 32'(bus.empty), 1);
        chk("mr_head_ptr", 32'(dut.head_q), 0);
        chk("mr_tail_ptr", 32'(dut.tail_q), 0);
        reset = 1'b0;
        bus.push_valid  = 1'b0;
        bus.read_enable = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
